// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SQUASH
    } fetch_state_t;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_TRAP,
        REDIR_BR,
        REDIR_JUMP
    } redir_t;

    localparam logic [31:0] INST_NOP = 32'h00000013;
    localparam logic [2:0]  PC_STEP  = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Trap outranks branch, branch outranks jump.
    function automatic redir_t redir_cause(
        input logic trap,
        input logic br,
        input logic jump
    );
        redir_t c;
        c = REDIR_NONE;
        if (trap)
            c = REDIR_TRAP;
        else if (br)
            c = REDIR_BR;
        else if (jump)
            c = REDIR_JUMP;
        return c;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory req/gnt/rvalid bus between fetch and imem.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small {pc, inst} buffer between fetch and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  fetch_entry_t               i_din,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = i_pop && (count != '0);
    assign do_push = i_push && ((count != CW'(DEPTH)) || do_pop);

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (i_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_din;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_valid = (count != '0);
    assign o_count = count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: pc, redirect arbitration, outstanding/stale tracking.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trap,
    input  logic [31:0] i_trap_target,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_halt,
    fetch_if.master     imem,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_id_ready,
    output logic        o_flush,
    output logic        o_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_n;
    fetch_state_t  issue_st;
    redir_t        cause;
    logic          redirect;
    logic [31:0]   target;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_n;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_n;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] buf_n;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          fire;
    logic          rv_acc;
    logic          push;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  head;
    fetch_entry_t  din;

    assign cause    = redir_cause(i_trap, i_br_taken, i_jump);
    assign redirect = (cause != REDIR_NONE);

    always_comb begin
        target = pc;
        unique case (cause)
            REDIR_TRAP: target = i_trap_target;
            REDIR_BR:   target = i_br_target;
            REDIR_JUMP: target = i_jump_target;
            default:    target = pc;
        endcase
    end

    // Responses return in order, so stale ones always precede live ones.
    assign fire   = (state == REQ) && imem.imem_gnt;
    assign rv_acc = imem.imem_rvalid && (outst != '0);
    assign push   = rv_acc && (drop == '0) && !redirect;
    assign pop    = head_valid && i_id_ready;

    assign outst_n = outst + CW'(fire) - CW'(rv_acc);
    assign buf_n   = redirect ? '0
                   : buf_cnt + CW'(push) - CW'(pop);
    assign drop_n  = redirect ? outst_n
                   : drop - CW'(rv_acc && (drop != '0));

    assign credit_sum = {1'b0, buf_n} + {1'b0, outst_n};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);

    assign din.pc   = resp_pc;
    assign din.inst = imem.imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (redirect),
        .i_push  (push),
        .i_din   (din),
        .i_pop   (pop),
        .o_head  (head),
        .o_valid (head_valid),
        .o_count (buf_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        issue_st = IDLE;
        if (credit_ok && !i_halt)
            issue_st = REQ;
        else if (outst_n != '0)
            issue_st = WAIT;
        if (redirect) begin
            if (state == REQ && !fire && !i_halt)
                state_n = REQ;
            else if (outst_n != '0)
                state_n = SQUASH;
            else
                state_n = issue_st;
        end else begin
            unique case (state)
                REQ:     state_n = fire ? issue_st : REQ;
                SQUASH:  state_n = (drop_n == '0) ? issue_st : SQUASH;
                default: state_n = issue_st;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc      <= RESET_ADDR;
            resp_pc <= RESET_ADDR;
            outst   <= '0;
            drop    <= '0;
        end else begin
            outst <= outst_n;
            drop  <= drop_n;
            if (redirect) begin
                pc      <= {target[31:2], 2'b00};
                resp_pc <= {target[31:2], 2'b00};
            end else begin
                if (fire)
                    pc <= pc + 32'(PC_STEP);
                if (push)
                    resp_pc <= resp_pc + 32'(PC_STEP);
            end
        end
    end

    always_comb begin
        imem.imem_req  = (state == REQ);
        imem.imem_addr = pc;
        o_inst_valid   = head_valid;
        o_inst         = head.inst;
        o_inst_pc      = head.pc;
        o_flush        = redirect;
        o_misalign     = redirect && (target[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an in-order imem model and stream scoreboard.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        i_rst;
    logic        i_trap;
    logic [31:0] i_trap_target;
    logic        i_br_taken;
    logic [31:0] i_br_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_halt;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_id_ready;
    logic        o_flush;
    logic        o_misalign;

    fetch_if imem();

    fetch_ctrl #(
        .RESET_ADDR (32'h00000000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_trap        (i_trap),
        .i_trap_target (i_trap_target),
        .i_br_taken    (i_br_taken),
        .i_br_target   (i_br_target),
        .i_jump        (i_jump),
        .i_jump_target (i_jump_target),
        .i_halt        (i_halt),
        .imem          (imem),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_id_ready    (i_id_ready),
        .o_flush       (o_flush),
        .o_misalign    (o_misalign)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          grants = 0;
    int          flush_cnt = 0;
    int          mis_cnt = 0;
    int          req_cnt;
    logic        gnt_on = 1;
    logic        gnt_alt = 0;
    logic        spurious = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        hold_v = 0;
    logic [31:0] hold_addr = 32'h0;
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] seen [$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] get_seen(input int k);
        return (seen.size() > k) ? seen[k] : 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mem_drive();
        cyc++;
        imem.imem_rvalid = 0;
        imem.imem_rdata  = 32'h0;
        if (spurious) begin
            imem.imem_rvalid = 1;
            imem.imem_rdata  = 32'hDEADBEEF;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem.imem_rvalid = 1;
            imem.imem_rdata  = memf(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        imem.imem_gnt = gnt_alt ? cyc[0] : gnt_on;
        if (imem.imem_req && imem.imem_gnt && !i_rst) begin
            pend_addr.push_back(imem.imem_addr);
            pend_due.push_back(cyc + lat);
            grants++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_drive();
    endtask

    task automatic do_reset();
        i_rst  = 1;
        exp_pc = 32'h0;
        hold_v = 0;
        pend_addr.delete();
        pend_due.delete();
        tick();
        tick();
        i_rst = 0;
    endtask

    task automatic run_until_seen(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (seen.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (seen.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d insts want %0d", name, seen.size(), n);
        end
    endtask

    task automatic wait_pending(input logic [31:0] a, input int budget, input string name);
        int  k;
        logic hit;
        k   = 0;
        hit = 0;
        while (!hit && k < budget) begin
            tick();
            k++;
            foreach (pend_addr[i])
                if (pend_addr[i] == a)
                    hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: fetch of %h never granted", name, a);
        end
    endtask

    // Scoreboard: decode must see an unbroken pc+4 stream from the last reset/redirect.
    initial begin : compare
        logic        red;
        logic [31:0] tgt;
        forever begin
            @(negedge clk);
            #1;
            if (i_rst) begin
                hold_v = 0;
            end else begin
                red = i_trap || i_br_taken || i_jump;
                if (i_trap)
                    tgt = i_trap_target;
                else if (i_br_taken)
                    tgt = i_br_target;
                else
                    tgt = i_jump_target;
                chk("flush", 32'(o_flush), 32'(red));
                chk("misalign", 32'(o_misalign), 32'(red && tgt[1:0] != 2'b00));
                if (red)
                    flush_cnt++;
                if (o_misalign)
                    mis_cnt++;
                if (hold_v) begin
                    chk("req_hold", 32'(imem.imem_req), 32'd1);
                    chk("addr_hold", imem.imem_addr, hold_addr);
                end
                hold_v    = imem.imem_req && !imem.imem_gnt && !red;
                hold_addr = imem.imem_addr;
                chk("credit", 32'(pend_addr.size() <= 2), 32'd1);
                if (o_inst_valid && i_id_ready && !red) begin
                    chk("inst_pc", o_inst_pc, exp_pc);
                    chk("inst", o_inst, memf(exp_pc));
                    seen.push_back(o_inst_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (red)
                    exp_pc = {tgt[31:2], 2'b00};
            end
        end
    end

    initial begin : stim
        logic [31:0] t1_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        i_rst = 1;
        i_trap = 0; i_trap_target = 32'h0;
        i_br_taken = 0; i_br_target = 32'h0;
        i_jump = 0; i_jump_target = 32'h0;
        i_halt = 0;
        i_id_ready = 1;
        imem.imem_gnt = 0;
        imem.imem_rvalid = 0;
        imem.imem_rdata = 32'h0;

        // Reset state
        tick();
        #1;
        chk("rst_req", 32'(imem.imem_req), 32'd0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_valid", 32'(o_inst_valid), 32'd0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_inst_pc", o_inst_pc, 32'h0);
        chk("rst_flush", 32'(o_flush), 32'd0);

        // 1: streaming
        do_reset();
        seen.delete();
        run_until_seen(8, 60, "t1_stream");
        for (int i = 0; i < 5; i++)
            chk("t1_pc", get_seen(i), t1_pc[i]);

        // 2: decode stall, then release with a stuttering grant
        i_id_ready = 0;
        do_reset();
        seen.delete();
        grants = 0;
        repeat (6) tick();
        #1;
        chk("t2_grants", 32'(grants), 32'd2);
        chk("t2_valid", 32'(o_inst_valid), 32'd1);
        chk("t2_head_pc", o_inst_pc, 32'h0);
        i_id_ready = 1;
        gnt_alt = 1;
        run_until_seen(6, 80, "t2_release");
        chk("t2_first", get_seen(0), 32'h0);
        chk("t2_second", get_seen(1), 32'h4);
        gnt_alt = 0;

        // 3: branch while fetch of 0x8 is outstanding
        lat = 3;
        do_reset();
        flush_cnt = 0;
        wait_pending(32'h8, 40, "t3_fetch8");
        tick();
        i_br_taken = 1; i_br_target = 32'h100;
        tick();
        i_br_taken = 0;
        seen.delete();
        chk("t3_flushes", 32'(flush_cnt), 32'd1);
        run_until_seen(2, 60, "t3_after");
        chk("t3_first", get_seen(0), 32'h100);
        chk("t3_second", get_seen(1), 32'h104);
        lat = 1;

        // 4: trap beats branch
        do_reset();
        repeat (3) tick();
        i_trap = 1; i_trap_target = 32'h80;
        i_br_taken = 1; i_br_target = 32'h200;
        tick();
        i_trap = 0; i_br_taken = 0;
        seen.delete();
        #1;
        chk("t4_addr", imem.imem_addr, 32'h80);
        run_until_seen(2, 40, "t4_after");
        chk("t4_first", get_seen(0), 32'h80);

        // 5: misaligned jump target
        do_reset();
        mis_cnt = 0;
        repeat (4) tick();
        i_jump = 1; i_jump_target = 32'h103;
        tick();
        i_jump = 0;
        seen.delete();
        #1;
        chk("t5_mis", 32'(mis_cnt), 32'd1);
        chk("t5_addr", imem.imem_addr, 32'h100);
        run_until_seen(2, 40, "t5_after");
        chk("t5_first", get_seen(0), 32'h100);

        // Halt, with a redirect taken while halted
        do_reset();
        repeat (4) tick();
        i_halt = 1;
        repeat (2) tick();
        req_cnt = 0;
        repeat (5) begin
            tick();
            if (imem.imem_req) req_cnt++;
        end
        chk("halt_noreq", 32'(req_cnt), 32'd0);
        i_br_taken = 1; i_br_target = 32'h40;
        tick();
        i_br_taken = 0;
        seen.delete();
        req_cnt = 0;
        repeat (3) begin
            tick();
            if (imem.imem_req) req_cnt++;
        end
        chk("halt_redir_noreq", 32'(req_cnt), 32'd0);
        chk("halt_redir_addr", imem.imem_addr, 32'h40);
        i_halt = 0;
        run_until_seen(2, 40, "halt_resume");
        chk("halt_first", get_seen(0), 32'h40);

        // 6: async reset mid-wait, stray response afterwards
        lat = 4;
        do_reset();
        wait_pending(32'h0, 20, "t6_fetch0");
        tick();
        #3;
        i_rst = 1;
        exp_pc = 32'h0;
        hold_v = 0;
        #1;
        chk("t6_async_req", 32'(imem.imem_req), 32'd0);
        chk("t6_async_valid", 32'(o_inst_valid), 32'd0);
        chk("t6_async_addr", imem.imem_addr, 32'h0);
        pend_addr.delete();
        pend_due.delete();
        spurious = 1;
        gnt_on = 0;
        tick();
        i_rst = 0;
        spurious = 0;
        gnt_on = 1;
        seen.delete();
        tick();
        #1;
        chk("t6_stray_dropped", 32'(o_inst_valid), 32'd0);
        chk("t6_addr", imem.imem_addr, 32'h0);
        run_until_seen(2, 60, "t6_after");
        chk("t6_first", get_seen(0), 32'h0);
        chk("t6_second", get_seen(1), 32'h4);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
